// File: rtl/sll.sv
// Shift-left-logical ALU unit: log2 barrel shifter with a registered result.
// Each accepted operation yields Y one cycle later; Y holds while idle.
module sll #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] B,
    output logic               out_valid,
    output logic [WIDTH-1:0]   Y
);

    logic [SHAMT_W:0][WIDTH-1:0] w_stage;
    logic [WIDTH-1:0]            r_y;
    logic                        r_out_valid;

    assign w_stage[0] = A;

    // Stage k conditionally shifts by 2**k, selected by B[k].
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_stage[k+1] = B[k] ? (w_stage[k] << SH) : w_stage[k];
    end

    // Y only loads on accept, so unknown operands while idle never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid)
                r_y <= w_stage[SHAMT_W];
        end
    end

    assign Y         = r_y;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sll.sv
// Scoreboard bench for sll: the driver queues expected (valid, Y) per cycle,
// and a monitor pops and compares one entry after each rising edge.
module tb_sll;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] A;
    logic [4:0]  B;
    logic        out_valid;
    logic [63:0] Y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [63:0] y;
        string       name;
    } exp_t;

    exp_t q[$];

    sll #(.WIDTH(64), .SHAMT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .Y        (Y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue what must appear after the next edge.
    task automatic drive(input logic v, input logic [63:0] a, input logic [4:0] b,
                         input logic exp_v, input logic [63:0] exp_y, input string name);
        exp_t e;
        @(negedge clk);
        #1;
        in_valid = v;
        A        = a;
        B        = b;
        e.v      = exp_v;
        e.y      = exp_y;
        e.name   = name;
        q.push_back(e);
    endtask

    // Monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check({e.name, ".valid"}, {63'd0, out_valid}, {63'd0, e.v});
            check({e.name, ".Y"}, Y, e.y);
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        #2;
        check("reset.valid", {63'd0, out_valid}, 64'd0);
        check("reset.Y", Y, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 64'd1, 5'd1, 1'b1, 64'd2, "basic");
        drive(1'b1, 64'hA, 5'd0, 1'b1, 64'hA, "noshift");
        drive(1'b1, 64'h8000_0000_0000_0000, 5'd7, 1'b1, 64'd0, "drop_msb");
        drive(1'b1, 64'hF000_0000_0000_0001, 5'd8, 1'b1, 64'h0000_0000_0000_0100, "drop_mix");
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1, 64'hFFFF_FFFF_8000_0000, "max_shift");
        drive(1'b1, 64'd0, 5'd19, 1'b1, 64'd0, "zero_a");
        drive(1'b1, 64'h0123_4567_89AB_CDEF, 5'd4, 1'b1, 64'h1234_5678_9ABC_DEF0, "nibble");
        drive(1'b1, 64'h0000_0000_0000_00FF, 5'd21, 1'b1, 64'h0000_0000_1FE0_0000, "mid");
        // Idle with unknown operands: Y must hold the last result.
        drive(1'b0, 64'hx, 5'hx, 1'b0, 64'h0000_0000_1FE0_0000, "idle_x");
        drive(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 5'd3, 1'b0, 64'h0000_0000_1FE0_0000, "idle_hold");

        for (int n = 0; n < 32; n++)
            drive(1'b1, 64'd1, 5'(n), 1'b1, 64'd1 << n, $sformatf("stream%0d", n));
        drive(1'b0, 64'd1, 5'd0, 1'b0, 64'h8000_0000, "stream_drop");

        // Mid-run asynchronous reset while out_valid is high.
        drive(1'b1, 64'd5, 5'd2, 1'b1, 64'd20, "pre_reset");
        @(posedge clk);
        #3;
        check("pre_reset.live_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset.valid", {63'd0, out_valid}, 64'd0);
        check("async_reset.Y", Y, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_hold.Y", Y, 64'd0);
        rst_n = 1'b1;

        drive(1'b1, 64'h3, 5'd30, 1'b1, 64'h0000_0000_C000_0000, "post_reset");
        drive(1'b0, 64'd0, 5'd0, 1'b0, 64'h0000_0000_C000_0000, "post_idle");

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        #5;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
